// File: rtl/serial_tx.sv
// Parallel-in, serial-out LSB-first transmitter for the core's output port.
// Each frame is one start bit, DATA_WIDTH data bits and one stop bit.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic                  txs_q, txs_d;
    logic                  baud_end;
    logic                  accept;

    assign baud_end  = (baud_q == BAUD_MAX);
    assign tx_ready  = (state_q == IDLE) || ((state_q == STOP) && baud_end);
    assign busy      = (state_q != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign tx_serial = txs_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            baud_q   <= '0;
            txs_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            txs_q    <= txs_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        baud_d   = '0;
        txs_d    = 1'b1;

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept in the last stop cycle restarts directly with no idle gap.
        if (accept) begin
            state_d  = START;
            shreg_d  = tx_data;
            bitcnt_d = '0;
            baud_d   = '0;
        end

        // The line flop tracks the next state so it stays aligned with it.
        if (state_d == START) begin
            txs_d = 1'b0;
        end else if (state_d == DATA) begin
            txs_d = shreg_d[0];
        end else begin
            txs_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one 8-bit/4-clk instance and one
// 5-bit/2-clk instance, sampled on the falling clock edge.
module tb_serial_tx;

    logic       clk;
    logic       clr;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic       a_serial;
    logic       a_busy;
    logic [4:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       b_serial;
    logic       b_busy;

    int n_tests;
    int n_fail;

    serial_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4)
    ) u_a (
        .clk      (clk),
        .clr      (clr),
        .tx_data  (a_data),
        .tx_valid (a_valid),
        .tx_ready (a_ready),
        .tx_serial(a_serial),
        .busy     (a_busy)
    );

    serial_tx #(
        .DATA_WIDTH  (5),
        .CLKS_PER_BIT(2)
    ) u_b (
        .clk      (clk),
        .clr      (clr),
        .tx_data  (b_data),
        .tx_valid (b_valid),
        .tx_ready (b_ready),
        .tx_serial(b_serial),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at the negedge of frame cycle 1 (first start-bit cycle).
    task automatic frame_a(input string name, input logic [7:0] d,
                           input logic nxt_valid, input logic [7:0] nxt_data,
                           input bit noise);
        logic exp_bit;
        int   idx;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            idx = (k - 1) / 4;
            if (idx == 0) exp_bit = 1'b0;
            else if (idx == 9) exp_bit = 1'b1;
            else exp_bit = d[idx-1];
            chk($sformatf("%s ser c%0d", name, k), 16'(a_serial), 16'(exp_bit));
            chk($sformatf("%s busy c%0d", name, k), 16'(a_busy), 16'd1);
            chk($sformatf("%s rdy c%0d", name, k), 16'(a_ready),
                16'(k == 40));
            if (k == 1) begin
                a_valid = nxt_valid;
                a_data  = nxt_data;
            end
            if (noise && k == 10) begin
                a_valid = 1'b1;
                a_data  = 8'hFF;
            end
            if (noise && k == 30) a_valid = 1'b0;
        end
    endtask

    task automatic idle_a(input string name);
        chk({name, " ser"}, 16'(a_serial), 16'd1);
        chk({name, " busy"}, 16'(a_busy), 16'd0);
        chk({name, " rdy"}, 16'(a_ready), 16'd1);
    endtask

    initial begin
        logic [6:0] b_line;
        n_tests = 0;
        n_fail  = 0;
        clr     = 1'b0;
        a_valid = 1'b0;
        a_data  = 8'h00;
        b_valid = 1'b0;
        b_data  = 5'h00;

        repeat (2) @(negedge clk);
        idle_a("rst");
        chk("rst b ser", 16'(b_serial), 16'd1);
        chk("rst b busy", 16'(b_busy), 16'd0);
        chk("rst b rdy", 16'(b_ready), 16'd1);
        clr = 1'b1;

        // Idle hold.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            idle_a($sformatf("idle %0d", i));
        end

        // Single frame A5.
        a_valid = 1'b1;
        a_data  = 8'hA5;
        @(negedge clk);
        frame_a("a5", 8'hA5, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        idle_a("a5 end");

        // Back-to-back 00 then FF with valid held.
        a_valid = 1'b1;
        a_data  = 8'h00;
        @(negedge clk);
        frame_a("b2b0", 8'h00, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        frame_a("b2b1", 8'hFF, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        idle_a("b2b end");

        // Ignore valid while busy.
        a_valid = 1'b1;
        a_data  = 8'h3C;
        @(negedge clk);
        frame_a("ign", 8'h3C, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        idle_a("ign end");
        @(negedge clk);
        idle_a("ign end2");

        // Asynchronous reset during third data bit of 0F.
        a_valid = 1'b1;
        a_data  = 8'h0F;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("mid busy", 16'(a_busy), 16'd1);
        chk("mid rdy", 16'(a_ready), 16'd0);
        #2 clr = 1'b0;
        #1;
        idle_a("async rst");
        @(negedge clk);
        idle_a("rst hold");
        clr = 1'b1;
        @(negedge clk);
        idle_a("rst rel");
        a_valid = 1'b1;
        a_data  = 8'h81;
        @(negedge clk);
        frame_a("x81", 8'h81, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        idle_a("x81 end");

        // Parameter sweep instance: 5'h13, 2 clocks per bit.
        b_line  = 7'b1100110;
        b_valid = 1'b1;
        b_data  = 5'h13;
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("sw ser c%0d", k), 16'(b_serial),
                16'(b_line[(k-1)/2]));
            chk($sformatf("sw busy c%0d", k), 16'(b_busy), 16'd1);
            chk($sformatf("sw rdy c%0d", k), 16'(b_ready), 16'(k == 14));
        end
        @(negedge clk);
        chk("sw end ser", 16'(b_serial), 16'd1);
        chk("sw end busy", 16'(b_busy), 16'd0);
        chk("sw end rdy", 16'(b_ready), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter for the processor's output port, LSB first.
- The processor core hands it a data word over a valid/ready handshake.
- It shifts the word out on a single line framed as one start bit (0), DATA_WIDTH data bits and one stop bit (1).
- It pairs with the team's serial receive path on the far end of the same line.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clock cycles each bit is held on tx_serial (>= 2).

Ports:
- clk  input  1  clock; all state changes on posedge.
- clr  input  1  asynchronous active-low reset.
- tx_data  input  DATA_WIDTH  word to send; sampled only at accept.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  transmitter can accept a word this cycle.
- tx_serial  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (clr low, asynchronous, any time including mid-frame):
  - state = IDLE; tx_serial = 1; tx_ready = 1; busy = 0.
  - Shift register, bit counter and baud counter all clear to 0.
  - Any frame in flight is abandoned; the partial frame is never resumed.
- Accept:
  - Occurs on a posedge where tx_valid & tx_ready are both 1.
  - tx_data is captured into the shift register on that edge.
  - tx_data and tx_valid are don't-care at all other times, including while busy.
- States: IDLE -> START -> DATA -> STOP -> IDLE (or STOP -> START, see back-to-back).
- IDLE:
  - tx_serial = 1, busy = 0, tx_ready = 1.
  - On accept -> START.
- START:
  - tx_serial = 0 for exactly CLKS_PER_BIT cycles, then -> DATA.
- DATA:
  - Shift register bit 0 is driven on tx_serial for CLKS_PER_BIT cycles.
  - Then shift right by one and increment the bit counter.
  - After DATA_WIDTH bits -> STOP.
- STOP:
  - tx_serial = 1 for CLKS_PER_BIT cycles, then -> IDLE.
- tx_ready is 1 in IDLE and in the final cycle of STOP only; it is 0 everywhere else.
- busy is 1 in START, DATA and STOP.
- Latency: tx_serial falls on the first posedge after accept (registered output, no combinational path from inputs).
- Frame length: exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back: an accept in the last STOP cycle goes directly to START with no idle gap. busy stays 1 across the boundary.
- Without an accept in the last STOP cycle, the block goes to IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1.
  - Wraps to 0 at each bit boundary.
  - Cleared on every accept.
- Bit counter: width is clog2(DATA_WIDTH+1); it never exceeds DATA_WIDTH.
- tx_serial is glitch-free: driven directly from a flop.

Test Plan:
- Single frame, CLKS_PER_BIT=4, DATA_WIDTH=8, tx_data=8'hA5 pulsed valid one cycle:
  - tx_serial = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total.
  - busy high for 40 cycles; tx_ready low for cycles 1..39 after accept.
- Back-to-back, tx_valid held high with 8'h00 then 8'hFF:
  - The second start bit follows the first stop bit with zero idle cycles.
  - Line reads 0, eight 0s, 1, 0, eight 1s, 1; busy never drops between frames.
- Ignore while busy:
  - Accept 8'h3C, then drive tx_valid=1 and tx_data=8'hFF mid-frame with the producer withdrawing before the last STOP cycle.
  - Only 8'h3C is transmitted; the block returns to IDLE with tx_serial=1.
- Reset mid-frame:
  - Assert clr low asynchronously (between clock edges) during the 3rd data bit of 8'h0F.
  - tx_serial=1, busy=0, tx_ready=1 immediately, without waiting for a clock edge.
  - After release, accepting 8'h81 produces a clean full frame.
- Idle hold: no tx_valid for 100 cycles after reset -> tx_serial stays 1, busy 0, tx_ready 1 throughout.
- Parameter sweep: DATA_WIDTH=5, CLKS_PER_BIT=2, tx_data=5'h13 -> line 0,1,1,0,0,1,1, each 2 cycles; 14 cycles total.
